// File: rtl/mimc_pkg.sv
// Shared types and constants for the MiMC request arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> RUN -> RESP -> IDLE)
//   MIMC_N_BITS : default field element / cipher block width
//   wdog_width  : watchdog counter width for a given timeout (never zero)
package mimc_pkg;

   localparam int unsigned MIMC_N_BITS = 254;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RESP
   } arb_state_t;

   // A disabled watchdog (timeout 0) still gets a 1-bit counter, which is simply held at 0.
   function automatic int unsigned wdog_width(input int unsigned timeout_cycles);
      return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/mimc_req_arbiter_if.sv
// Bundle of every signal between the arbiter, its requesters/consumer and the MiMC core.
//   slave  : the arbiter side (takes requests, drives responses and the core)
//   master : the environment side (requesters, response consumer, core)
// Signals:
//   req_valid/req_ready/req_data : per-requester request handshake, requester i at
//                                  req_data[i*N_BITS +: N_BITS]
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data/rsp_id/rsp_err      : cipher result, served requester, watchdog error flag
//   core_en/core_in              : start/hold and operand for the MiMC core
//   core_out/core_done           : result and completion from the MiMC core
//   busy                         : arbiter not idle
interface mimc_req_arbiter_if #(
   parameter int unsigned N_BITS = mimc_pkg::MIMC_N_BITS,
   parameter int unsigned N_REQ  = 4
);
   localparam int unsigned ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ*N_BITS-1:0] req_data;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [N_BITS-1:0]       rsp_data;
   logic [ID_W-1:0]         rsp_id;
   logic                    rsp_err;
   logic                    core_en;
   logic [N_BITS-1:0]       core_in;
   logic [N_BITS-1:0]       core_out;
   logic                    core_done;
   logic                    busy;

   modport slave (
      input  req_valid, req_data, rsp_ready, core_out, core_done,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, core_en, core_in, busy
   );

   modport master (
      output req_valid, req_data, rsp_ready, core_out, core_done,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, core_en, core_in, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker.
//   req : request vector
//   ptr : index that currently has top priority
//   gnt : one-hot grant (all zero when no request)
//   idx : binary index of the granted request
//   any : at least one request present
// Requests at or above ptr are tried first (masked set); if none, the full vector is used,
// which gives the wrap-around without building a doubled request vector.
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [N-1:0] mask;
   logic [N-1:0] req_hi;
   logic [N-1:0] pick_src;

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      req_hi   = req & mask;
      pick_src = (|req_hi) ? req_hi : req;
      // Isolate the lowest set bit.
      gnt      = pick_src & (~pick_src + N'(1));
      idx      = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            idx = IDX_W'(i);
         end
      end
      any = |req;
   end

endmodule

// File: rtl/mimc_req_arbiter.sv
// Shares one MiMC cipher core between N_REQ requesters. A round-robin grant accepts one
// request in IDLE, the core runs in RUN (with an optional watchdog), and the tagged result is
// offered in RESP until the consumer takes it. Only one request is ever in flight.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mimc_req_arbiter_if.slave (request, response and core signals)
module mimc_req_arbiter
   import mimc_pkg::*;
#(
   parameter int unsigned N_BITS         = MIMC_N_BITS,
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input logic               clk,
   input logic               rst,
   mimc_req_arbiter_if.slave bus
);

   localparam int unsigned ID_W   = $clog2(N_REQ);
   localparam int unsigned WDOG_W = wdog_width(TIMEOUT_CYCLES);
   localparam logic [WDOG_W-1:0] WDOG_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : WDOG_W'(TIMEOUT_CYCLES - 1);

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   prio_q, prio_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [N_BITS-1:0] core_in_q, core_in_d;
   logic [N_BITS-1:0] rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic              rsp_err_q, rsp_err_d;

   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_idx;
   logic              gnt_any;

   rr_arbiter #(
      .N(N_REQ)
   ) u_rr (
      .req (bus.req_valid),
      .ptr (prio_q),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      wdog_d     = wdog_q;
      core_in_d  = core_in_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rsp_err_d  = rsp_err_q;

      unique case (state_q)
         IDLE: begin
            // req_ready equals gnt here, so any grant is a completed transfer.
            if (gnt_any) begin
               core_in_d = bus.req_data[gnt_idx*N_BITS +: N_BITS];
               rsp_id_d  = gnt_idx;
               prio_d    = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
               wdog_d    = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (TIMEOUT_CYCLES != 0) begin
               wdog_d = wdog_q + 1'b1;
            end
            // Completion takes precedence over a watchdog expiry in the same cycle.
            if (bus.core_done) begin
               rsp_data_d = bus.core_out;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (wdog_q == WDOG_LAST)) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         prio_q     <= '0;
         wdog_q     <= '0;
         core_in_q  <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         wdog_q     <= wdog_d;
         core_in_q  <= core_in_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Grant is masked during reset so req_ready reads zero while rst is held.
   assign bus.req_ready = ((state_q == IDLE) && !rst) ? gnt : '0;
   assign bus.core_en   = (state_q == RUN);
   assign bus.core_in   = core_in_q;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
